// File: rtl/prog_loader.sv
// Instruction-memory writer: packs a byte stream into words, writes them from
// address 0 upward and holds the core stalled until the image is in place.
module prog_loader #(
    parameter int data_length = 32,
    parameter int mem_length  = 32,
    localparam int BYTES = data_length / 8,
    localparam int AW    = (mem_length > 1) ? $clog2(mem_length) : 1,
    localparam int LW    = $clog2(mem_length + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [LW-1:0]          load_len,
    input  logic [7:0]             in_byte,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   wr_en,
    output logic [AW-1:0]          wr_addr,
    output logic [data_length-1:0] wr_data,
    output logic                   busy,
    output logic                   cpu_hold,
    output logic                   done,
    output logic                   err
);

    localparam int KW = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [KW-1:0]          kcnt_q, kcnt_d;
    logic [AW-1:0]          idx_q, idx_d;
    logic [LW-1:0]          len_q, len_d;
    logic [data_length-1:0] word_q, word_d;
    logic [AW-1:0]          wr_addr_q, wr_addr_d;
    logic [data_length-1:0] wr_data_q, wr_data_d;
    logic                   err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            kcnt_q    <= '0;
            idx_q     <= '0;
            len_q     <= '0;
            word_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            kcnt_q    <= kcnt_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            word_q    <= word_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        kcnt_d    = kcnt_q;
        idx_d     = idx_q;
        len_d     = len_q;
        word_d    = word_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_d     = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (load_len == '0) begin
                        state_d = DONE;
                        err_d   = 1'b0;
                    end else if (load_len > LW'(mem_length)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = COLLECT;
                        err_d   = 1'b0;
                        idx_d   = '0;
                        kcnt_d  = '0;
                        len_d   = load_len;
                    end
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    word_d[{kcnt_q, 3'b000} +: 8] = in_byte;
                    if (kcnt_q == KW'(BYTES - 1)) begin
                        // Output regs load here so they are valid during WRITE
                        state_d   = WRITE;
                        kcnt_d    = '0;
                        wr_addr_d = idx_q;
                        wr_data_d = word_d;
                    end else begin
                        kcnt_d = kcnt_q + KW'(1);
                    end
                end
            end
            WRITE: begin
                if (LW'(idx_q) == len_q - LW'(1)) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + AW'(1);
                    kcnt_d  = '0;
                    state_d = COLLECT;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready = (state_q == COLLECT);
    assign wr_en    = (state_q == WRITE);
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = (state_q != IDLE);
    assign cpu_hold = busy;
    assign done     = (state_q == DONE);
    assign err      = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: scoreboard of expected memory writes,
// a shadow instruction memory and done-pulse timing.
module tb_prog_loader;

    localparam int DL = 32;
    localparam int ML = 32;
    localparam int NB = DL / 8;
    localparam int AW = $clog2(ML);
    localparam int LW = $clog2(ML + 1);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DL-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] load_len = '0;
    logic [7:0]    in_byte = '0;
    logic          in_valid = 1'b0;
    logic          in_ready, wr_en, busy, cpu_hold, done, err;
    logic [AW-1:0] wr_addr;
    logic [DL-1:0] wr_data;

    int nassert = 0;
    int nfail = 0;
    int wr_count = 0;
    int done_count = 0;
    wr_t sb_q[$];
    logic [DL-1:0] shadow [ML];
    logic [7:0] img [ML*NB];

    prog_loader #(.data_length(DL), .mem_length(ML)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .load_len(load_len),
        .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: pops the scoreboard and fills the shadow memory
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            wr_t e;
            wr_count++;
            nassert++;
            assert (sb_q.size() > 0) else begin
                nfail++;
                $error("FAIL unexpected_write observed=%0h expected=none",
                       wr_addr);
            end
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("wr_addr", 64'(wr_addr), 64'(e.addr));
                chk("wr_data", 64'(wr_data), 64'(e.data));
            end
            shadow[wr_addr] = wr_data;
        end
        if (rst_n && done) done_count++;
    end

    function automatic logic [DL-1:0] img_word(input int w);
        logic [DL-1:0] v;
        for (int b = 0; b < NB; b++) v[8*b +: 8] = img[w*NB + b];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one load; returns cycle of the done pulse (1 = cycle after start)
    task automatic run_load(input int n, input bit gaps, input bit restart,
                            output int done_cyc);
        int cyc, b, total;
        bit acc, tog;
        done_cyc = 0;
        start = 1'b1;
        load_len = LW'(n);
        tick();
        start = 1'b0;
        cyc = 1;
        if (done) done_cyc = cyc;
        b = 0;
        tog = 1'b1;
        total = n * NB;
        while (b < total && cyc < 2000) begin
            in_valid = gaps ? tog : 1'b1;
            in_byte = img[b];
            if (restart && b == 2) begin
                start = 1'b1;
                load_len = LW'(5);
            end else begin
                start = 1'b0;
            end
            acc = in_valid && in_ready;
            if (acc && (b % NB) == NB - 1)
                sb_q.push_back('{addr: AW'(b / NB), data: img_word(b / NB)});
            tick();
            cyc++;
            if (acc) b++;
            tog = ~tog;
            if (done && done_cyc == 0) done_cyc = cyc;
        end
        in_valid = 1'b0;
        start = 1'b0;
        while (done_cyc == 0 && cyc < 2000) begin
            tick();
            cyc++;
            if (done) done_cyc = cyc;
        end
        chk("load_timeout", 64'(cyc < 2000), 64'(1));
        tick();
    endtask

    initial begin
        int dc, wc0, dn0;
        foreach (img[i]) img[i] = 8'($urandom);
        img[0] = 8'h01; img[1] = 8'h00; img[2] = 8'h0C; img[3] = 8'h30;

        // Reset state
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_wr_en", 64'(wr_en), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_cpu_hold", 64'(cpu_hold), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_wr_addr", 64'(wr_addr), 64'(0));
        chk("rst_wr_data", 64'(wr_data), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();

        // Single word
        run_load(1, 1'b0, 1'b0, dc);
        chk("t1_done_cyc", 64'(dc), 64'(6));
        chk("t1_wr_count", 64'(wr_count), 64'(1));
        chk("t1_word", 64'(shadow[0]), 64'(32'h300C0001));
        chk("t1_busy_after", 64'(busy), 64'(0));
        chk("t1_hold_after", 64'(cpu_hold), 64'(0));
        chk("t1_done_count", 64'(done_count), 64'(1));

        // Full memory, continuous stream
        wc0 = wr_count;
        run_load(ML, 1'b0, 1'b0, dc);
        chk("t2_done_cyc", 64'(dc), 64'(ML * (NB + 1) + 1));
        chk("t2_wr_count", 64'(wr_count - wc0), 64'(ML));
        for (int i = 0; i < ML; i++)
            chk("t2_readback", 64'(shadow[i]), 64'(img_word(i)));

        // Gapped stream
        foreach (img[i]) img[i] = 8'($urandom);
        wc0 = wr_count;
        run_load(2, 1'b1, 1'b0, dc);
        chk("t3_wr_count", 64'(wr_count - wc0), 64'(2));
        chk("t3_word0", 64'(shadow[0]), 64'(img_word(0)));
        chk("t3_word1", 64'(shadow[1]), 64'(img_word(1)));
        chk("t3_done_late", 64'(dc > 2 * (NB + 1) + 1), 64'(1));

        // Zero length, then oversize, then recovery
        wc0 = wr_count;
        run_load(0, 1'b0, 1'b0, dc);
        chk("t4_zero_done_cyc", 64'(dc), 64'(1));
        chk("t4_zero_writes", 64'(wr_count - wc0), 64'(0));
        dn0 = done_count;
        start = 1'b1;
        load_len = LW'(ML + 1);
        tick();
        start = 1'b0;
        chk("t4_err_set", 64'(err), 64'(1));
        chk("t4_err_busy", 64'(busy), 64'(0));
        repeat (6) tick();
        chk("t4_err_writes", 64'(wr_count - wc0), 64'(0));
        chk("t4_err_no_done", 64'(done_count - dn0), 64'(0));
        chk("t4_err_sticky", 64'(err), 64'(1));
        run_load(1, 1'b0, 1'b0, dc);
        chk("t4_err_cleared", 64'(err), 64'(0));
        chk("t4_recover_cyc", 64'(dc), 64'(NB + 2));

        // Start re-asserted mid-load
        foreach (img[i]) img[i] = 8'($urandom);
        wc0 = wr_count;
        run_load(3, 1'b0, 1'b1, dc);
        chk("t5_done_cyc", 64'(dc), 64'(3 * (NB + 1) + 1));
        chk("t5_wr_count", 64'(wr_count - wc0), 64'(3));
        chk("t5_word2", 64'(shadow[2]), 64'(img_word(2)));

        // Reset after two words of a four-word load
        foreach (img[i]) img[i] = 8'($urandom);
        wc0 = wr_count;
        dn0 = done_count;
        start = 1'b1;
        load_len = LW'(4);
        tick();
        start = 1'b0;
        for (int b = 0; b < 2 * NB + 1; b++) begin
            in_valid = 1'b1;
            in_byte = img[b];
            if ((b % NB) == NB - 1)
                sb_q.push_back('{addr: AW'(b / NB), data: img_word(b / NB)});
            tick();
            if ((b % NB) == NB - 1) tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_busy", 64'(busy), 64'(0));
        chk("t6_in_ready", 64'(in_ready), 64'(0));
        chk("t6_wr_addr", 64'(wr_addr), 64'(0));
        chk("t6_wr_data", 64'(wr_data), 64'(0));
        chk("t6_writes", 64'(wr_count - wc0), 64'(2));
        chk("t6_sb_empty", 64'(sb_q.size()), 64'(0));
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_no_done", 64'(done_count - dn0), 64'(0));
        foreach (img[i]) img[i] = 8'($urandom);
        wc0 = wr_count;
        run_load(2, 1'b0, 1'b0, dc);
        chk("t6_reload_cyc", 64'(dc), 64'(2 * (NB + 1) + 1));
        chk("t6_reload_writes", 64'(wr_count - wc0), 64'(2));
        chk("t6_reload_w0", 64'(shadow[0]), 64'(img_word(0)));
        chk("sb_final_empty", 64'(sb_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nassert, nfail);
        $finish;
    end

endmodule
